seg_display_scan: RTL and testbench



---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_display_scan_if.sv | 33 +++
 rtl/bcd_to_seg.sv | 31 +++
 rtl/seg_display_scan.sv | 154 +++++++++++++++
 tb/tb_seg_display_scan.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan driver.
//   - state_e   : scan FSM states (blank dead-time / digit drive)
//   - SEG_*     : active-low segment patterns, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/seg_display_scan_if.sv
// ---------------------------------------------------------------------------
// seg_display_scan_if
//   Bundle between the BCD counter chain, the scan driver and the pins.
//   master : upstream counters / board side (drives load, bcd, dp)
//   slave  : the scan driver (drives seg_n, dp_n, an_n, frame_done, state)
//
//   Handshake: load is a single-cycle capture strobe with no back-pressure.
//   Whenever load is 1 on a clk edge, bcd and dp are taken on that edge;
//   there is no ready, the driver always accepts.
//   state is a debug view of the scan FSM.
// ---------------------------------------------------------------------------
interface seg_display_scan_if #(
  parameter int NUM_DIGITS = 3
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd;
  logic [NUM_DIGITS-1:0]     dp;
  logic [6:0]                seg_n;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      frame_done;
  seg_pkg::state_e           state;

  modport master (
    output load, bcd, dp,
    input  seg_n, dp_n, an_n, frame_done, state
  );

  modport slave (
    input  load, bcd, dp,
    output seg_n, dp_n, an_n, frame_done, state
  );
endinterface

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
//   Purely combinational BCD nibble to common-anode segment decoder.
//   nib_i : 4-bit digit value
//   seg_o : active-low segments {g,f,e,d,c,b,a}; values above 9 show a dash
// ---------------------------------------------------------------------------
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// ---------------------------------------------------------------------------
// seg_display_scan
//   Time-multiplexed 7-segment scan driver for a common-anode display.
//   Each digit slot lasts DIV_CYCLES clocks: BLANK_CYCLES of dead time with
//   every anode off, then the digit is driven for the rest of the slot.
//   The BCD word is snapshotted on load so a counter rollover cannot tear a
//   frame; the shown pattern is decoded once on entry to DRIVE and held.
//
//   Ports:
//     clk     : system clock
//     reset_n : asynchronous active-low reset
//     bus     : seg_display_scan_if.slave
//               in  load, bcd[4*NUM_DIGITS], dp[NUM_DIGITS]
//               out seg_n[7], dp_n, an_n[NUM_DIGITS], frame_done, state
//   All outputs are registered.
// ---------------------------------------------------------------------------
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  seg_display_scan_if.slave   bus
);

  localparam int PW = $clog2(DIV_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Snapshot of the counter word
  logic [4*NUM_DIGITS-1:0] snap_bcd_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;

  // Scan FSM state and registered outputs
  state_e                  state_q;
  logic [PW-1:0]           presc_q;
  logic [IW-1:0]           idx_q;
  logic [6:0]              seg_n_q;
  logic                    dp_n_q;
  logic [NUM_DIGITS-1:0]   an_n_q;
  logic                    frame_done_q;

  logic [PW-1:0]           presc_d;
  logic [IW-1:0]           idx_d;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              dec_seg;
  logic [6:0]              drive_seg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
    end else if (bus.load) begin
      snap_bcd_q <= bus.bcd;
      snap_dp_q  <= bus.dp;
    end
  end

  assign presc_d = presc_q + PW'(1);
  assign idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  // Select the current digit's nibble, decimal point and anode
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    an_sel  = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_q == IW'(j)) begin
        cur_nib   = snap_bcd_q[4*j +: 4];
        cur_dp    = snap_dp_q[j];
        an_sel[j] = 1'b0;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant digit are
  // zero; digit 0 always shows so a zero value still reads "0".
  always_comb begin
    lz_blank = 1'b0;
    if (LZ_SUPPRESS != 0 && idx_q != '0) begin
      lz_blank = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (IW'(j) >= idx_q && snap_bcd_q[4*j +: 4] != 4'h0) begin
          lz_blank = 1'b0;
        end
      end
    end
  end

  bcd_to_seg u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  assign drive_seg = lz_blank ? SEG_BLANK : dec_seg;

  // Scan FSM. The prescaler counts across the whole slot (blank + drive) and
  // only clears at the end of the slot, so slot length is exactly DIV_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BLANK;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_BLANK: begin
          presc_q <= presc_d;
          if (presc_q == BLANK_LAST) begin
            state_q <= ST_DRIVE;
            seg_n_q <= drive_seg;
            dp_n_q  <= ~cur_dp;
            an_n_q  <= an_sel;
          end
        end
        ST_DRIVE: begin
          if (presc_q == DIV_LAST) begin
            state_q      <= ST_BLANK;
            presc_q      <= '0;
            idx_q        <= idx_d;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= (idx_q == IDX_LAST);
          end else begin
            presc_q <= presc_d;
          end
        end
        default: state_q <= ST_BLANK;
      endcase
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;
  import seg_pkg::*;

  localparam int N     = 3;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_scan_if #(.NUM_DIGITS(N)) if0 ();
  seg_display_scan_if #(.NUM_DIGITS(N)) if1 ();

  seg_display_scan #(
    .NUM_DIGITS(N), .DIV_CYCLES(DIV), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(0)
  ) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0)
  );

  seg_display_scan #(
    .NUM_DIGITS(N), .DIV_CYCLES(DIV), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(1)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1)
  );

  // ---------------- reference model ----------------
  int         total = 0;
  int         bad   = 0;
  int         n;          // clk edges since reset release
  logic [11:0] m_bcd;     // model snapshot
  logic [2:0]  m_dp;
  logic [3:0]  sh_nib;    // digit value latched for the current drive slot
  logic        sh_dp;
  logic        sh_lz;
  logic [6:0]  seg_tab [16];

  task automatic model_reset();
    n = 0; m_bcd = '0; m_dp = '0;
    sh_nib = '0; sh_dp = 1'b0; sh_lz = 1'b0;
  endtask

  // One clk edge: a slot enters drive when its position reaches BLK; the
  // digit shown is taken from the snapshot as it stood before this edge.
  task automatic model_edge(input logic ld, input logic [11:0] b, input logic [2:0] d);
    int q, dg;
    n++;
    q  = n % DIV;
    dg = (n / DIV) % N;
    if (q == BLK) begin
      sh_nib = m_bcd[4*dg +: 4];
      sh_dp  = m_dp[dg];
      sh_lz  = (dg != 0) && ((m_bcd >> (4*dg)) == 12'h000);
    end
    if (ld) begin
      m_bcd = b;
      m_dp  = d;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d obs=%0h exp=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       drive;
    int         dg;
    logic [2:0] one;
    logic [2:0] e_an;
    logic [6:0] e_seg0, e_seg1;
    logic       e_dp, e_fd;
    one   = 3'b001;
    drive = (n % DIV) >= BLK;
    dg    = (n / DIV) % N;
    e_an   = drive ? ~(one << dg) : 3'b111;
    e_seg0 = drive ? seg_tab[sh_nib] : 7'h7F;
    e_seg1 = drive ? (sh_lz ? 7'h7F : seg_tab[sh_nib]) : 7'h7F;
    e_dp   = drive ? ~sh_dp : 1'b1;
    e_fd   = (n % FRAME) == 0;
    check("an0",    32'(if0.an_n),       32'(e_an));
    check("seg0",   32'(if0.seg_n),      32'(e_seg0));
    check("dp0",    32'(if0.dp_n),       32'(e_dp));
    check("fd0",    32'(if0.frame_done), 32'(e_fd));
    check("st0",    32'(if0.state),      32'(drive));
    check("an1",    32'(if1.an_n),       32'(e_an));
    check("seg1",   32'(if1.seg_n),      32'(e_seg1));
    check("dp1",    32'(if1.dp_n),       32'(e_dp));
    check("fd1",    32'(if1.frame_done), 32'(e_fd));
    check("st1",    32'(if1.state),      32'(drive));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg0"}, 32'(if0.seg_n),      32'h7F);
    check({tag, "_dp0"},  32'(if0.dp_n),       32'h1);
    check({tag, "_an0"},  32'(if0.an_n),       32'h7);
    check({tag, "_fd0"},  32'(if0.frame_done), 32'h0);
    check({tag, "_st0"},  32'(if0.state),      32'(ST_BLANK));
    check({tag, "_seg1"}, 32'(if1.seg_n),      32'h7F);
    check({tag, "_an1"},  32'(if1.an_n),       32'h7);
    check({tag, "_fd1"},  32'(if1.frame_done), 32'h0);
  endtask

  // ---------------- driver ----------------
  logic [11:0] cur_b;
  logic [2:0]  cur_d;

  task automatic tick(input logic ld, input logic [11:0] b, input logic [2:0] d);
    if0.load = ld; if0.bcd = b; if0.dp = d;
    if1.load = ld; if1.bcd = b; if1.dp = d;
    cur_b = b; cur_d = d;
    @(posedge clk);
    model_edge(ld, b, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, cur_b, cur_d);
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int guard;
    logic [11:0] rb;
    if0.load = 1'b0; if0.bcd = '0; if0.dp = '0;
    if1.load = 1'b0; if1.bcd = '0; if1.dp = '0;
    cur_b = '0; cur_d = '0;
    model_reset();

    // power-on reset
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    model_reset();

    // zero snapshot before any load
    run(30);

    // basic scan 059
    tick(1'b1, 12'h059, 3'b000);
    run(50);

    // leading-zero cases
    tick(1'b1, 12'h005, 3'b000);
    run(30);
    tick(1'b1, 12'h000, 3'b000);
    run(30);

    // invalid nibble with decimal point on digit 1
    tick(1'b1, 12'h0A3, 3'b010);
    run(30);

    // tear-free load mid-drive of digit 0
    tick(1'b1, 12'h058, 3'b000);
    guard = 0;
    while ((n % FRAME) != 3 && guard < 100) begin
      tick(1'b0, cur_b, cur_d);
      guard++;
    end
    check("tear_align", 32'(n % FRAME), 32'd3);
    tick(1'b1, 12'h059, 3'b000);
    run(30);

    // reset mid-drive: outputs drop immediately
    guard = 0;
    while ((n % DIV) != 4 && guard < 100) begin
      tick(1'b0, cur_b, cur_d);
      guard++;
    end
    check("mid_drive", 32'(if0.state), 32'(ST_DRIVE));
    reset_n = 1'b0;
    #1;
    check_reset("rst_async");
    @(negedge clk);
    check_reset("rst_hold");
    reset_n = 1'b1;
    model_reset();
    run(10);

    // load held high while bcd ramps
    for (int i = 0; i < 72; i++) begin
      rb = {4'((i / 100) % 10), 4'((i / 10) % 10), 4'(i % 10)};
      tick(1'b1, rb, 3'($urandom_range(0, 7)));
    end

    // random stimulus, zeros favoured to exercise suppression
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        rb[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      tick($urandom_range(0, 5) == 0, rb, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
